// File: rtl/sbox_sched.sv
// Shares NSBOX external S-box lanes between AES SubBytes (16 bytes) and SubWord (4 bytes).
// Jobs are granted from IDLE and streamed NSBOX bytes per cycle through the lanes.
module sbox_sched #(
    parameter int NSBOX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_req,
    input  logic [127:0]       st_in,
    output logic               st_gnt,
    output logic               st_done,
    output logic [127:0]       st_out,
    input  logic               kw_req,
    input  logic [31:0]        kw_in,
    output logic               kw_gnt,
    output logic               kw_done,
    output logic [31:0]        kw_out,
    output logic [8*NSBOX-1:0] sb_in,
    input  logic [8*NSBOX-1:0] sb_out,
    output logic               busy
);

    localparam int W    = 8 * NSBOX;
    localparam int N_ST = 16 / NSBOX;
    localparam int N_KW = 4 / NSBOX;

    generate
        if (!((NSBOX == 1) || (NSBOX == 2) || (NSBOX == 4))) begin : g_bad_nsbox
            $error("sbox_sched: NSBOX must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } state_t;

    state_t         state_r, state_nx_s;
    logic [3:0]     cnt_r, cnt_nx_s;
    logic           last_kw_r;
    logic           grant_st_s, grant_kw_s, tie_s;
    logic           st_last_s, kw_last_s;
    logic           st_done_nx_s, kw_done_nx_s, busy_nx_s;
    logic [127:0]   st_op_r, st_stage_r, st_merge_s, st_out_r;
    logic [31:0]    kw_op_r, kw_stage_r, kw_merge_s, kw_out_r;
    logic [W-1:0]   sb_in_r, sb_in_nx_s;
    logic           st_gnt_r, kw_gnt_r, st_done_r, kw_done_r, busy_r;

    assign st_last_s = (cnt_r == 4'(N_ST - 1));
    assign kw_last_s = (cnt_r == 4'(N_KW - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state and arbitration: ties go to whoever was not served by the previous tie
    always_comb begin
        state_nx_s = state_r;
        grant_st_s = 1'b0;
        grant_kw_s = 1'b0;
        tie_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (st_req && kw_req) begin
                    tie_s = 1'b1;
                    if (last_kw_r) begin
                        grant_st_s = 1'b1;
                    end else begin
                        grant_kw_s = 1'b1;
                    end
                end else if (kw_req) begin
                    grant_kw_s = 1'b1;
                end else if (st_req) begin
                    grant_st_s = 1'b1;
                end else begin
                    tie_s = 1'b0;
                end
                if (grant_kw_s) begin
                    state_nx_s = KW_RUN;
                end else if (grant_st_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ST_RUN: begin
                if (st_last_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            KW_RUN: begin
                if (kw_last_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = KW_RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: done pulses, busy and chunk counter for the next cycle
    always_comb begin
        st_done_nx_s = (state_r == ST_RUN) && st_last_s;
        kw_done_nx_s = (state_r == KW_RUN) && kw_last_s;
        busy_nx_s    = (state_nx_s != IDLE);
        if ((state_r == IDLE) || (state_nx_s == IDLE)) begin
            cnt_nx_s = 4'd0;
        end else begin
            cnt_nx_s = cnt_r + 4'd1;
        end
    end

    // Lane datapath: merge current lane results and pick the bytes to present next cycle
    always_comb begin
        st_merge_s = st_stage_r;
        kw_merge_s = kw_stage_r;
        for (int c = 0; c < N_ST; c++) begin
            st_merge_s[127-W*c -: W] = (cnt_r == 4'(c)) ? sb_out : st_stage_r[127-W*c -: W];
        end
        for (int c = 0; c < N_KW; c++) begin
            kw_merge_s[31-W*c -: W] = (cnt_r == 4'(c)) ? sb_out : kw_stage_r[31-W*c -: W];
        end
        sb_in_nx_s = {W{1'b0}};
        case (state_r)
            IDLE: begin
                if (grant_st_s) begin
                    sb_in_nx_s = st_in[127 -: W];
                end else if (grant_kw_s) begin
                    sb_in_nx_s = kw_in[31 -: W];
                end else begin
                    sb_in_nx_s = {W{1'b0}};
                end
            end
            ST_RUN: begin
                for (int c = 0; c < N_ST - 1; c++) begin
                    sb_in_nx_s = (cnt_r == 4'(c)) ? st_op_r[127-W*(c+1) -: W] : sb_in_nx_s;
                end
            end
            KW_RUN: begin
                for (int c = 0; c < N_KW - 1; c++) begin
                    sb_in_nx_s = (cnt_r == 4'(c)) ? kw_op_r[31-W*(c+1) -: W] : sb_in_nx_s;
                end
            end
            default: sb_in_nx_s = {W{1'b0}};
        endcase
    end

    // Control registers: counter, tie history, handshake pulses, lane drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            last_kw_r <= 1'b0;
            st_gnt_r  <= 1'b0;
            kw_gnt_r  <= 1'b0;
            st_done_r <= 1'b0;
            kw_done_r <= 1'b0;
            busy_r    <= 1'b0;
            sb_in_r   <= {W{1'b0}};
        end else begin
            cnt_r     <= cnt_nx_s;
            last_kw_r <= tie_s ? grant_kw_s : last_kw_r;
            st_gnt_r  <= grant_st_s;
            kw_gnt_r  <= grant_kw_s;
            st_done_r <= st_done_nx_s;
            kw_done_r <= kw_done_nx_s;
            busy_r    <= busy_nx_s;
            sb_in_r   <= sb_in_nx_s;
        end
    end

    // Operand latches, result staging and held results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_op_r    <= 128'd0;
            kw_op_r    <= 32'd0;
            st_stage_r <= 128'd0;
            kw_stage_r <= 32'd0;
            st_out_r   <= 128'd0;
            kw_out_r   <= 32'd0;
        end else begin
            st_op_r    <= grant_st_s ? st_in : st_op_r;
            kw_op_r    <= grant_kw_s ? kw_in : kw_op_r;
            st_stage_r <= (state_r == ST_RUN) ? st_merge_s : st_stage_r;
            kw_stage_r <= (state_r == KW_RUN) ? kw_merge_s : kw_stage_r;
            st_out_r   <= st_done_nx_s ? st_merge_s : st_out_r;
            kw_out_r   <= kw_done_nx_s ? kw_merge_s : kw_out_r;
        end
    end

    assign st_gnt  = st_gnt_r;
    assign kw_gnt  = kw_gnt_r;
    assign st_done = st_done_r;
    assign kw_done = kw_done_r;
    assign st_out  = st_out_r;
    assign kw_out  = kw_out_r;
    assign sb_in   = sb_in_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched with NSBOX = 4, 2 and 1 instances side by side.
// The S-box lanes are modelled from the GF(2^8) definition; expected results are FIPS-197 vectors.
module tb_sbox_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         st_req [3];
    logic [127:0] st_in  [3];
    logic         st_gnt [3];
    logic         st_done[3];
    logic [127:0] st_out [3];
    logic         kw_req [3];
    logic [31:0]  kw_in  [3];
    logic         kw_gnt [3];
    logic         kw_done[3];
    logic [31:0]  kw_out [3];
    logic [31:0]  sb_in_a[3];
    logic         busy   [3];

    int checks = 0;
    int errors = 0;
    logic [127:0] st_q[$];
    logic [31:0]  kw_q[$];

    localparam logic [127:0] ST_VEC = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ST_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [31:0]  KW_VEC = 32'hcf4f3c09;
    localparam logic [31:0]  KW_EXP = 32'h8a84eb01;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
        logic [8*NS-1:0] sbi, sbo;
        for (genvar j = 0; j < NS; j++) begin : g_lane
            assign sbo[8*NS-1-8*j -: 8] = sbox(sbi[8*NS-1-8*j -: 8]);
        end
        assign sb_in_a[g] = 32'(sbi);
        sbox_sched #(.NSBOX(NS)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .st_req(st_req[g]), .st_in(st_in[g]), .st_gnt(st_gnt[g]),
            .st_done(st_done[g]), .st_out(st_out[g]),
            .kw_req(kw_req[g]), .kw_in(kw_in[g]), .kw_gnt(kw_gnt[g]),
            .kw_done(kw_done[g]), .kw_out(kw_out[g]),
            .sb_in(sbi), .sb_out(sbo), .busy(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nsb(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
    endfunction

    function automatic logic flag(input int sel, input int d);
        case (sel)
            0: return st_gnt[d];
            1: return st_done[d];
            2: return kw_gnt[d];
            3: return kw_done[d];
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ev(input int sel, input int d, input int maxc, input string tag, output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!flag(sel, d) && (k < maxc));
        if (!flag(sel, d)) chk({tag, "_timeout"}, 128'(flag(sel, d)), 128'd1);
    endtask

    task automatic run_st(input int d, input logic [127:0] vec, input logic [127:0] exp);
        int k1, k2;
        st_in[d] = vec; st_req[d] = 1'b1;
        st_q.push_back(exp);
        wait_ev(0, d, 4, "st_gnt", k1);
        chk("st_gnt_cycle", 128'(k1), 128'd1);
        st_req[d] = 1'b0;
        wait_ev(1, d, 40, "st_done", k2);
        chk("st_latency", 128'(k1 + k2), 128'(16 / nsb(d) + 1));
        chk("st_out", st_out[d], st_q.pop_front());
        chk("st_busy_done", 128'(busy[d]), 128'd0);
        chk("st_sb_in_idle", 128'(sb_in_a[d]), 128'd0);
    endtask

    task automatic run_kw(input int d, input logic [31:0] vec, input logic [31:0] exp);
        int k1, k2;
        kw_in[d] = vec; kw_req[d] = 1'b1;
        kw_q.push_back(exp);
        wait_ev(2, d, 4, "kw_gnt", k1);
        chk("kw_gnt_cycle", 128'(k1), 128'd1);
        kw_req[d] = 1'b0;
        wait_ev(3, d, 20, "kw_done", k2);
        chk("kw_latency", 128'(k1 + k2), 128'(4 / nsb(d) + 1));
        chk("kw_out", 128'(kw_out[d]), 128'(kw_q.pop_front()));
        chk("kw_st_done_quiet", 128'(st_done[d]), 128'd0);
    endtask

    initial begin
        int k;
        logic [31:0] held;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            st_req[d] = 1'b0; st_in[d] = 128'd0;
            kw_req[d] = 1'b0; kw_in[d] = 32'd0;
        end
        #2;
        chk("rst_busy", 128'(busy[0]), 128'd0);
        chk("rst_st_out", st_out[0], 128'd0);
        chk("rst_kw_out", 128'(kw_out[0]), 128'd0);
        chk("rst_sb_in", 128'(sb_in_a[0]), 128'd0);
        chk("rst_gnts", 128'({st_gnt[0], kw_gnt[0], st_done[0], kw_done[0]}), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Lane-count sweep: same vectors on NSBOX = 4, 2, 1
        for (int d = 0; d < 3; d++) begin
            run_st(d, ST_VEC, ST_EXP);
            run_kw(d, KW_VEC, KW_EXP);
        end

        // First tie after reset goes to KW, ST follows right after kw_done
        st_in[0] = ST_VEC; kw_in[0] = KW_VEC;
        st_req[0] = 1'b1; kw_req[0] = 1'b1;
        kw_q.push_back(KW_EXP); st_q.push_back(ST_EXP);
        tick();
        chk("tie1_kw_gnt", 128'(kw_gnt[0]), 128'd1);
        chk("tie1_st_gnt", 128'(st_gnt[0]), 128'd0);
        kw_req[0] = 1'b0;
        wait_ev(3, 0, 10, "tie1_kw_done", k);
        chk("tie1_kw_out", 128'(kw_out[0]), 128'(kw_q.pop_front()));
        tick();
        chk("tie1_st_gnt_after", 128'(st_gnt[0]), 128'd1);
        st_req[0] = 1'b0;
        wait_ev(1, 0, 10, "tie1_st_done", k);
        chk("tie1_st_out", st_out[0], st_q.pop_front());

        // Second tie goes to ST
        st_req[0] = 1'b1; kw_req[0] = 1'b1;
        st_q.push_back(ST_EXP); kw_q.push_back(KW_EXP);
        tick();
        chk("tie2_st_gnt", 128'(st_gnt[0]), 128'd1);
        chk("tie2_kw_gnt", 128'(kw_gnt[0]), 128'd0);
        st_req[0] = 1'b0;
        wait_ev(1, 0, 10, "tie2_st_done", k);
        chk("tie2_st_out", st_out[0], st_q.pop_front());
        tick();
        chk("tie2_kw_gnt_after", 128'(kw_gnt[0]), 128'd1);
        kw_req[0] = 1'b0;
        wait_ev(3, 0, 10, "tie2_kw_done", k);
        chk("tie2_kw_out", 128'(kw_out[0]), 128'(kw_q.pop_front()));

        // Abort an ST job during chunk 2 with an asynchronous reset
        st_in[0] = ST_VEC; st_req[0] = 1'b1;
        tick();
        chk("abort_gnt", 128'(st_gnt[0]), 128'd1);
        st_req[0] = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy[0]), 128'd0);
        chk("abort_st_out", st_out[0], 128'd0);
        chk("abort_st_done", 128'(st_done[0]), 128'd0);
        st_in[0] = 128'd0; st_req[0] = 1'b1;
        tick();
        chk("abort_st_done_rst", 128'(st_done[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        st_q.push_back({16{8'h63}});
        wait_ev(0, 0, 4, "abort_regnt", k);
        chk("abort_regnt_cycle", 128'(k), 128'd1);
        st_req[0] = 1'b0;
        wait_ev(1, 0, 10, "abort_redone", k);
        chk("abort_st_zero_vec", st_out[0], st_q.pop_front());

        // Held request receives a second job
        kw_in[0] = KW_VEC; kw_req[0] = 1'b1;
        kw_q.push_back(KW_EXP); kw_q.push_back(KW_EXP);
        wait_ev(2, 0, 4, "held_gnt", k);
        wait_ev(3, 0, 10, "held_done1", k);
        chk("held_done1_cycle", 128'(k), 128'd1);
        held = kw_out[0];
        chk("held_kw_out1", 128'(held), 128'(kw_q.pop_front()));
        tick();
        chk("held_regrant", 128'(kw_gnt[0]), 128'd1);
        kw_req[0] = 1'b0;
        chk("held_kw_out_stable", 128'(kw_out[0]), 128'(held));
        wait_ev(3, 0, 10, "held_done2", k);
        chk("held_kw_out2", 128'(kw_out[0]), 128'(kw_q.pop_front()));
        tick();
        chk("held_no_third", 128'(kw_gnt[0]), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_sched.md
Name: sbox_sched

Overview:
- Shares a small bank of combinational S-box lookup instances between two requesters:
  - the round datapath's SubBytes, which needs 16 bytes;
  - the key expansion's SubWord, which needs 4 bytes.
- Time-multiplexes the bank NSBOX bytes per cycle, arbitrates between the two requesters, latches their operands and returns substituted results with a done pulse.
- Sits between the AES round controller / key scheduler and the instantiated S-box bank. The S-box instances themselves are external to this block.

Parameters:
- NSBOX, 4, number of parallel S-box lanes. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- st_req  in  1  SubBytes request, level. Must be held with st_in stable until st_gnt.
- st_in  in  128  state operand. Byte k = st_in[127-8k -: 8], k=0..15.
- st_gnt  out  1  one-cycle pulse: st_in has been latched.
- st_done  out  1  one-cycle pulse: st_out is updated.
- st_out  out  128  substituted state, same byte order as st_in. Held until the next st_done.
- kw_req  in  1  SubWord request, level. Must be held with kw_in stable until kw_gnt.
- kw_in  in  32  word operand. Byte k = kw_in[31-8k -: 8], k=0..3.
- kw_gnt  out  1  one-cycle pulse: kw_in has been latched.
- kw_done  out  1  one-cycle pulse: kw_out is updated.
- kw_out  out  32  substituted word. Held until the next kw_done.
- sb_in  out  8*NSBOX  bytes to the S-box lanes. Lane j = sb_in[8*NSBOX-1-8j -: 8].
- sb_out  in  8*NSBOX  combinational results from the lanes, same lane order.
- busy  out  1  high when the FSM is not IDLE.

Behaviour:
- Reset: FSM=IDLE, chunk counter=0, last_grant=ST.
  - All gnt/done/busy outputs = 0.
  - st_out=0, kw_out=0, sb_in=0.
  - Operand latches = 0.
- FSM states: IDLE, ST_RUN, KW_RUN.
- IDLE, at a rising edge:
  - Only kw_req high: go to KW_RUN.
  - Only st_req high: go to ST_RUN.
  - Both high: round-robin. Serve the requester that is not last_grant, then update last_grant. After reset the first tie goes to KW.
  - On entry to a RUN state: latch the operand, clear the counter, and register the matching gnt. gnt is therefore high during the first RUN cycle.
- RUN states:
  - Chunk count N = 16/NSBOX for ST and 4/NSBOX for KW.
  - Each cycle, sb_in = latched bytes [cnt*NSBOX .. cnt*NSBOX+NSBOX-1].
  - At the edge, sb_out is written into the result staging register at the same byte positions, then cnt increments.
  - At the edge that captures chunk N-1: copy staging to st_out or kw_out, register the matching done, and go to IDLE.
- Latency: a request sampled at edge E0 gives done high in the cycle after edge E_N.
  - Example, NSBOX=4: ST done 5 cycles after sampling; KW done 2 cycles after sampling.
  - Throughput is one job per N+1 cycles.
- Back-to-back: the done cycle is an IDLE cycle, so a request held high is sampled again at the end of that cycle.
  - A requester must drop req in its gnt cycle, or it receives a second job.
- Requests arriving during RUN wait and are not lost. Their operands are latched only at grant.
- sb_in = 0 in IDLE.
- busy is high during RUN states only.
- st_out and kw_out never change except on their own done.
- Reset asserted mid-operation aborts the job:
  - no done is issued;
  - outputs return to their reset values;
  - after reset release, a still-asserted request is served afresh.
- Each gnt and each done is exactly one cycle wide. The two gnts are never high together; the two dones are never high together.

Test Plan:
- FIPS-197 SubBytes, NSBOX=4:
  - Stimulus: st_in = 193de3bea0f4e22b9ac68d2ae9f84808.
  - Required: st_out = d42711aee0bf98f1b8b45de51e415230; st_gnt in cycle 1, st_done 5 cycles after sampling.
- SubWord, NSBOX=4:
  - Stimulus: kw_in = cf4f3c09.
  - Required: kw_out = 8a84eb01; kw_done 2 cycles after sampling.
- Arbitration:
  - Stimulus: st_req and kw_req rise together after reset, both held until gnt.
  - Required: KW served first; ST granted in the cycle after kw_done.
  - Then repeat the tie: ST is now served first.
- Lane count sweep:
  - Stimulus: NSBOX=1 and NSBOX=2 with the same vectors as the first two scenarios.
  - Required: identical results; ST latency 17 and 9 cycles; KW latency 5 and 3 cycles.
- Abort:
  - Stimulus: assert rst_n=0 during chunk 2 of an ST job.
  - Required: no st_done; st_out=0; busy=0 immediately (asynchronous).
  - Then re-request 00 × 16 → st_out = 63 × 16.
- Held request:
  - Stimulus: keep kw_req high through kw_gnt.
  - Required: a second kw_gnt in the IDLE/done cycle + 1; kw_out stable between dones.
